keypad_reader: RTL and testbench

- Scans a 4x4 matrix keypad (Digilent Pmod KYPD), debounces it, and decodes one key press at a time.
- Accumulates decimal digit entry into a 16-bit binary value, converting decimal to binary. This is the input-side counterpart of the 4-digit display driver.
- The live accumulator can feed the display directly.
- The entered value is offered to the bus through a valid/ack handshake.

---
 rtl/keypad_reader.sv | 174 +++++++++++++++++
 tb/tb_keypad_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_reader.sv
// Scans and debounces a 4x4 matrix keypad and accumulates decimal digit entry into a 16-bit value.
// Enter latches the accumulator and offers it to a consumer through a valid/rd_ack handshake.
module keypad_reader #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] acc_value,
    output logic [15:0] entered_value,
    output logic        valid,
    input  logic        rd_ack,
    output logic [3:0]  key_code,
    output logic        key_strobe
);
    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [4:0] DEC_NONE  = 5'd16;
    localparam logic [4:0] DEC_MULTI = 5'd17;

    typedef enum logic {IDLE, PRESSED} state_t;

    state_t            state, state_d;
    logic [3:0]        row_s1, row_s2;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic [15:0]       key_map;
    logic [4:0]        prev_dec;
    logic [DEB_W-1:0]  deb_cnt;

    logic              slot_last, scan_end, stable;
    logic [15:0]       full_map;
    logic [4:0]        dec, n_low;
    logic [3:0]        hit;
    logic [DEB_W-1:0]  deb_next;
    logic [15:0]       acc_d, entered_d;
    logic              valid_d, strobe_d;
    logic [3:0]        code_d;
    logic [19:0]       digit_sum;

    // Map bit index is col*4 + row; returns the legend printed on that key.
    function automatic logic [3:0] key_lut(input logic [3:0] idx);
        case (idx)
            4'd0:  key_lut = 4'h1;
            4'd1:  key_lut = 4'h4;
            4'd2:  key_lut = 4'h7;
            4'd3:  key_lut = 4'h0;
            4'd4:  key_lut = 4'h2;
            4'd5:  key_lut = 4'h5;
            4'd6:  key_lut = 4'h8;
            4'd7:  key_lut = 4'hF;
            4'd8:  key_lut = 4'h3;
            4'd9:  key_lut = 4'h6;
            4'd10: key_lut = 4'h9;
            4'd11: key_lut = 4'hE;
            4'd12: key_lut = 4'hA;
            4'd13: key_lut = 4'hB;
            4'd14: key_lut = 4'hC;
            default: key_lut = 4'hD;
        endcase
    endfunction

    assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign scan_end  = slot_last && (col_idx == 2'd3);
    // Column 3 is being sampled on the scan-end edge, so it comes straight from the synchronizer.
    assign full_map  = {row_s2, key_map[11:0]};

    always_comb begin
        n_low = 5'd0;
        hit   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (!full_map[i]) begin
                n_low = n_low + 5'd1;
                hit   = key_lut(4'(i));
            end
        end
        if (n_low == 5'd0)      dec = DEC_NONE;
        else if (n_low == 5'd1) dec = {1'b0, hit};
        else                    dec = DEC_MULTI;
    end

    always_comb begin
        if (dec != prev_dec)                             deb_next = DEB_W'(1);
        else if (deb_cnt == DEB_W'(DEBOUNCE_SCANS))      deb_next = deb_cnt;
        else                                             deb_next = deb_cnt + DEB_W'(1);
    end
    assign stable = (deb_next == DEB_W'(DEBOUNCE_SCANS));

    // Scan timing, synchronizer and debounce history.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1   <= 4'b1111;
            row_s2   <= 4'b1111;
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            col      <= 4'b1110;
            key_map  <= 16'hFFFF;
            prev_dec <= DEC_NONE;
            deb_cnt  <= '0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (slot_last) begin
                slot_cnt                      <= '0;
                key_map[{col_idx, 2'b00} +: 4] <= row_s2;
                col_idx                       <= col_idx + 2'd1;
                col                           <= ~(4'b0001 << (col_idx + 2'd1));
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if (scan_end) begin
                prev_dec <= dec;
                deb_cnt  <= deb_next;
            end
        end
    end

    // Press FSM and key actions.
    always_comb begin
        state_d   = state;
        acc_d     = acc_value;
        entered_d = entered_value;
        valid_d   = valid & ~rd_ack;
        code_d    = key_code;
        strobe_d  = 1'b0;
        digit_sum = 20'(acc_value) * 20'd10 + 20'(dec[3:0]);
        case (state)
            IDLE: begin
                if (scan_end && stable && !dec[4]) begin
                    state_d  = PRESSED;
                    code_d   = dec[3:0];
                    strobe_d = 1'b1;
                    case (dec[3:0])
                        4'hA: acc_d = acc_value / 16'd10;
                        4'hC: acc_d = 16'd0;
                        4'hE: begin
                            entered_d = acc_value;
                            valid_d   = 1'b1;
                            acc_d     = 16'd0;
                        end
                        4'hB, 4'hD, 4'hF: ;
                        default: begin
                            if (digit_sum <= 20'd65535) acc_d = digit_sum[15:0];
                        end
                    endcase
                end
            end
            PRESSED: begin
                if (scan_end && stable && (dec == DEC_NONE)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc_value     <= 16'd0;
            entered_value <= 16'd0;
            valid         <= 1'b0;
            key_code      <= 4'h0;
            key_strobe    <= 1'b0;
        end else begin
            state         <= state_d;
            acc_value     <= acc_d;
            entered_value <= entered_d;
            valid         <= valid_d;
            key_code      <= code_d;
            key_strobe    <= strobe_d;
        end
    end
endmodule

// File: tb/tb_keypad_reader.sv
// Self-checking bench for keypad_reader: a keypad model drives rows from col, a scoreboard
// queue holds the expected result of every press and is checked on each key_strobe.
module tb_keypad_reader;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned HOLD     = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row, col;
    logic [15:0] acc_value, entered_value;
    logic        valid, rd_ack, key_strobe;
    logic [3:0]  key_code;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] acc;
        logic [15:0] ent;
        logic        vld;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] pressed;
    logic [15:0] m_acc, m_ent;
    logic        m_valid;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_strobes = 0;

    keypad_reader #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .acc_value(acc_value),
        .entered_value(entered_value), .valid(valid), .rd_ack(rd_ack),
        .key_code(key_code), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int key_index(input logic [3:0] code);
        case (code)
            4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
            4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
            4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
            4'h0: return 12; 4'hF: return 13; 4'hE: return 14; default: return 15;
        endcase
    endfunction

    task automatic apply_model(input logic [3:0] code);
        int t;
        case (code)
            4'hA: m_acc = m_acc / 16'd10;
            4'hC: m_acc = 16'd0;
            4'hE: begin m_ent = m_acc; m_valid = 1'b1; m_acc = 16'd0; end
            4'hB, 4'hD, 4'hF: ;
            default: begin
                t = int'(m_acc) * 10 + int'(code);
                if (t <= 65535) m_acc = 16'(t);
            end
        endcase
        exp_q.push_back('{code: code, acc: m_acc, ent: m_ent, vld: m_valid});
    endtask

    task automatic press(input logic [3:0] code);
        apply_model(code);
        pressed = 16'd0;
        pressed[key_index(code)] = 1'b1;
        repeat (HOLD) @(negedge clk);
        pressed = 16'd0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_acc = 16'd0; m_ent = 16'd0; m_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_col"}, 32'(col), 32'(4'b1110));
        check({tag, "_acc"}, 32'(acc_value), 0);
        check({tag, "_ent"}, 32'(entered_value), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_code"}, 32'(key_code), 0);
        check({tag, "_strobe"}, 32'(key_strobe), 0);
    endtask

    // Enter whose strobe edge coincides with rd_ack: press aligned to a scan start so the
    // strobe lands on the second scan-end edge, 32 clocks later.
    task automatic enter_with_ack();
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            prev = col;
            @(negedge clk);
            if (prev == 4'b0111 && col == 4'b1110) found = 1'b1;
        end
        check("align_scan", 32'(found), 1);
        apply_model(4'hE);
        pressed = 16'd0;
        pressed[key_index(4'hE)] = 1'b1;
        repeat (31) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check("strobe_on_ack", 32'(key_strobe), 1);
        check("enter_wins_valid", 32'(valid), 1);
        @(negedge clk);
        check("enter_wins_hold", 32'(valid), 1);
        repeat (HOLD - 33) @(negedge clk);
        pressed = 16'd0;
        repeat (HOLD) @(negedge clk);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && key_strobe) begin
            n_strobes++;
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sb_key_code", 32'(key_code), 32'(mon_e.code));
                check("sb_acc", 32'(acc_value), 32'(mon_e.acc));
                check("sb_entered", 32'(entered_value), 32'(mon_e.ent));
                check("sb_valid", 32'(valid), 32'(mon_e.vld));
            end
        end
    end

    initial begin
        logic [3:0] ec;
        int         s;
        pressed = 16'd0;
        rd_ack  = 1'b0;
        do_reset();
        check_zero("reset");
        for (int k = 0; k < 16; k++) begin
            ec = 4'b1111;
            ec[(k / 4) % 4] = 1'b0;
            check("col_scan", 32'(col), 32'(ec));
            @(negedge clk);
        end

        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("acc_1234", 32'(acc_value), 1234);
        press(4'hE);
        check("enter_ent", 32'(entered_value), 1234);
        check("enter_valid", 32'(valid), 1);
        check("enter_acc", 32'(acc_value), 0);
        pulse_ack();
        check("ack_clears", 32'(valid), 0);
        pulse_ack();
        check("ack_idle_ignored", 32'(valid), 0);
        check("ack_idle_ent", 32'(entered_value), 1234);

        press(4'h9); press(4'hE);
        press(4'h5);
        enter_with_ack();
        check("enter_ack_ent", 32'(entered_value), 5);
        pulse_ack();
        check("ack_clears2", 32'(valid), 0);

        press(4'h6); press(4'h5); press(4'h5); press(4'h3); press(4'h5);
        check("acc_65535", 32'(acc_value), 65535);
        press(4'h0);
        check("overflow_hold", 32'(acc_value), 65535);
        press(4'hC);
        press(4'h6); press(4'h5); press(4'h5); press(4'h3); press(4'h6);
        check("overflow_6553", 32'(acc_value), 6553);
        press(4'hC);

        press(4'h1); press(4'h2); press(4'h3);
        press(4'hA);
        check("backspace", 32'(acc_value), 12);
        press(4'hC);
        check("clear", 32'(acc_value), 0);
        press(4'hB);
        check("key_b_code", 32'(key_code), 11);
        check("key_b_acc", 32'(acc_value), 0);

        s = n_strobes;
        pressed = 16'd0; pressed[key_index(4'h1)] = 1'b1;
        repeat (16) @(negedge clk);
        pressed = 16'd0;
        repeat (HOLD) @(negedge clk);
        check("glitch_no_strobe", 32'(n_strobes - s), 0);

        s = n_strobes;
        pressed = 16'd0;
        pressed[key_index(4'h1)] = 1'b1;
        pressed[key_index(4'h2)] = 1'b1;
        repeat (HOLD) @(negedge clk);
        pressed = 16'd0;
        repeat (HOLD) @(negedge clk);
        check("multi_no_strobe", 32'(n_strobes - s), 0);

        s = n_strobes;
        apply_model(4'h5);
        pressed = 16'd0; pressed[key_index(4'h5)] = 1'b1;
        repeat (160) @(negedge clk);
        pressed = 16'd0;
        repeat (HOLD) @(negedge clk);
        check("held_one_strobe", 32'(n_strobes - s), 1);
        check("held_acc", 32'(acc_value), 5);

        apply_model(4'h5);
        pressed = 16'd0; pressed[key_index(4'h5)] = 1'b1;
        repeat (HOLD) @(negedge clk);
        check("pre_reset_acc", 32'(acc_value), 55);
        do_reset();
        check_zero("held_reset");
        s = n_strobes;
        apply_model(4'h5);
        repeat (HOLD + 32) @(negedge clk);
        pressed = 16'd0;
        repeat (HOLD) @(negedge clk);
        check("post_reset_strobe", 32'(n_strobes - s), 1);
        check("post_reset_acc", 32'(acc_value), 5);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
